// File: rtl/sobel_window_3x3.sv
// 3x3 neighbourhood window generator for a raster-order pixel stream.
// Two line memories supply the previous rows; border windows are suppressed.
module sobel_window_3x3 #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned DATA_W     = 8,
    localparam int unsigned CW = $clog2(IMG_WIDTH),
    localparam int unsigned RW = $clog2(IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [DATA_W-1:0]     data_i,
    output logic [9*DATA_W-1:0]   window_o,
    output logic                  valid_o,
    output logic [CW-1:0]         center_col_o,
    output logic [RW-1:0]         center_row_o,
    output logic                  done_o
);

    localparam logic [CW-1:0] ColLast = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] RowLast = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    logic [DATA_W-1:0]      win_q [9];
    logic [DATA_W-1:0]      win_d [9];
    logic [9*DATA_W-1:0]    window_q, window_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic [CW-1:0]          ccol_q, ccol_d;
    logic [RW-1:0]          crow_q, crow_d;

    logic [DATA_W-1:0]      line_a [IMG_WIDTH];
    logic [DATA_W-1:0]      line_b [IMG_WIDTH];
    logic [DATA_W-1:0]      top, mid;
    logic                   last_col, last_row;

    // Read-before-write: the old contents feed the window this cycle.
    assign top      = line_b[col_q];
    assign mid      = line_a[col_q];
    assign last_col = (col_q == ColLast);
    assign last_row = (row_q == RowLast);

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        win_d    = win_q;
        window_d = window_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        ccol_d   = ccol_q;
        crow_d   = crow_q;
        if (valid_i) begin
            for (int i = 0; i < 3; i++) begin
                win_d[3*i]     = win_q[3*i+1];
                win_d[3*i + 1] = win_q[3*i+2];
            end
            win_d[2] = top;
            win_d[5] = mid;
            win_d[8] = data_i;
            // Columns 0/1 only prime the shift registers, so no window spans two rows.
            if (row_q >= RW'(2) && col_q >= CW'(2)) begin
                valid_d = 1'b1;
                for (int k = 0; k < 9; k++) begin
                    window_d[k*DATA_W +: DATA_W] = win_d[k];
                end
                ccol_d = col_q - CW'(1);
                crow_d = row_q - RW'(1);
            end
            done_d = last_col && last_row;
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q    <= '0;
            row_q    <= '0;
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= '0;
            end
            window_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            ccol_q   <= '0;
            crow_q   <= '0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            win_q    <= win_d;
            window_q <= window_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            ccol_q   <= ccol_d;
            crow_q   <= crow_d;
        end
    end

    // Line memories are never cleared; row gating hides stale contents.
    always_ff @(posedge clk) begin
        if (valid_i) begin
            line_b[col_q] <= line_a[col_q];
            line_a[col_q] <= data_i;
        end
    end

    assign window_o     = window_q;
    assign valid_o      = valid_q;
    assign done_o       = done_q;
    assign center_col_o = ccol_q;
    assign center_row_o = crow_q;

endmodule

// File: tb/tb_sobel_window_3x3.sv
// Self-checking bench for sobel_window_3x3 (8x6 image): per-cycle reference model
// over a frame buffer, plus a table of known windows and hand-written reset sequences.
module tb_sobel_window_3x3;

    localparam int W = 8;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [7:0]  data_i;
    logic [71:0] window_o;
    logic        valid_o;
    logic [2:0]  center_col_o;
    logic [2:0]  center_row_o;
    logic        done_o;

    sobel_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .data_i       (data_i),
        .window_o     (window_o),
        .valid_o      (valid_o),
        .center_col_o (center_col_o),
        .center_row_o (center_row_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [71:0] pack9(input int p[9]);
        logic [71:0] v = '0;
        for (int k = 0; k < 9; k++) v[k*8 +: 8] = p[k][7:0];
        return v;
    endfunction

    // Reference model: the current frame's pixels kept as a 2-D image.
    int          pix [H][W];
    int          m_r, m_c;
    logic        exp_valid, exp_done;
    logic [71:0] exp_win;
    int          exp_cr, exp_cc;
    bit          mon_on = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_r = 0; m_c = 0;
            exp_valid = 0; exp_done = 0; exp_win = '0; exp_cr = 0; exp_cc = 0;
        end else begin
            exp_valid = 0;
            exp_done  = 0;
            if (valid_i) begin
                pix[m_r][m_c] = int'(data_i);
                if (m_r >= 2 && m_c >= 2) begin
                    exp_valid = 1;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            exp_win[(3*i+j)*8 +: 8] = pix[m_r-2+i][m_c-2+j][7:0];
                    exp_cr = m_r - 1;
                    exp_cc = m_c - 1;
                end
                if (m_r == H-1 && m_c == W-1) exp_done = 1;
                m_c++;
                if (m_c == W) begin
                    m_c = 0;
                    m_r = (m_r == H-1) ? 0 : m_r + 1;
                end
            end
        end
    end

    // Capture of emitted windows, keyed by centre position.
    logic [71:0] cap [H][W];
    logic [71:0] ref_win [H][W];
    int          cap_cnt, done_cnt;
    int          ord_r[$], ord_c[$];

    always @(negedge clk) begin
        if (mon_on) begin
            chk("valid_o", {71'b0, valid_o}, {71'b0, exp_valid});
            chk("done_o", {71'b0, done_o}, {71'b0, exp_done});
            chk("window_o", window_o, exp_win);
            chk("center", {66'b0, center_row_o, center_col_o},
                {66'b0, 3'(exp_cr), 3'(exp_cc)});
            if (valid_o === 1'b1) begin
                cap[center_row_o][center_col_o] = window_o;
                cap_cnt++;
                ord_r.push_back(int'(center_row_o));
                ord_c.push_back(int'(center_col_o));
            end
            if (done_o === 1'b1) done_cnt++;
        end
    end

    typedef struct {
        string name;
        int    tst;
        int    cr;
        int    cc;
        int    px[9];
    } vec_t;
    vec_t vecs[5];

    task automatic check_table(input int tst);
        foreach (vecs[k])
            if (vecs[k].tst == tst)
                chk(vecs[k].name, cap[vecs[k].cr][vecs[k].cc], pack9(vecs[k].px));
    endtask

    task automatic pix_in(input logic v, input logic [7:0] d);
        @(negedge clk);
        valid_i = v;
        data_i  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) pix_in(1'b0, 8'($urandom));
    endtask

    task automatic clear_cap();
        cap_cnt = 0; done_cnt = 0;
        ord_r.delete(); ord_c.delete();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) cap[r][c] = '0;
    endtask

    // mode 0: ramp, 1: 255-ramp, 2: random. Stops after (stop_r, stop_c) if stop_r >= 0.
    task automatic send_frame(input int mode, input bit stall, input int stop_r, input int stop_c);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                logic [7:0] v;
                if (stall && $urandom_range(0, 2) == 0) idle($urandom_range(1, 5));
                case (mode)
                    0:       v = 8'(r*W + c);
                    1:       v = 8'(255 - (r*W + c));
                    default: v = 8'($urandom);
                endcase
                pix_in(1'b1, v);
                if (r == stop_r && c == stop_c) return;
            end
        end
    endtask

    task automatic compare_ref(input string name);
        for (int r = 1; r < H-1; r++)
            for (int c = 1; c < W-1; c++)
                chk(name, cap[r][c], ref_win[r][c]);
    endtask

    initial begin
        vecs[0] = '{"t2_first_window", 2, 1, 1, '{0, 1, 2, 8, 9, 10, 16, 17, 18}};
        vecs[1] = '{"t3_row_end_window", 2, 1, 6, '{5, 6, 7, 13, 14, 15, 21, 22, 23}};
        vecs[2] = '{"t3_next_row_window", 2, 2, 1, '{8, 9, 10, 16, 17, 18, 24, 25, 26}};
        vecs[3] = '{"t2_last_window", 2, 4, 6, '{29, 30, 31, 37, 38, 39, 45, 46, 47}};
        vecs[4] = '{"t5_frame2_first", 5, 1, 1,
                    '{255, 254, 253, 247, 246, 245, 239, 238, 237}};

        // T1: reset held for 3 cycles, then released idle.
        rst = 1'b1; valid_i = 1'b0; data_i = '0;
        repeat (3) @(negedge clk);
        mon_on = 1;
        rst = 1'b0;
        clear_cap();
        @(negedge clk);
        chk("t1_valid_o", {71'b0, valid_o}, 72'd0);
        chk("t1_done_o", {71'b0, done_o}, 72'd0);
        chk("t1_window_o", window_o, 72'd0);
        idle(3);

        // T2/T3: continuous ramp frame.
        clear_cap();
        send_frame(0, 0, -1, 0);
        idle(3);
        chk("t2_window_count", 72'(cap_cnt), 72'd24);
        chk("t2_done_count", 72'(done_cnt), 72'd1);
        check_table(2);
        chk("t3_order_row_end", 72'(ord_r[5]*8 + ord_c[5]), 72'(1*8 + 6));
        chk("t3_order_next_row", 72'(ord_r[6]*8 + ord_c[6]), 72'(2*8 + 1));
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) ref_win[r][c] = cap[r][c];

        // T4: same ramp with random stall gaps.
        clear_cap();
        send_frame(0, 1, -1, 0);
        idle(3);
        chk("t4_window_count", 72'(cap_cnt), 72'd24);
        compare_ref("t4_window_vs_t2");

        // T5: ramp then inverted ramp, back to back.
        clear_cap();
        send_frame(0, 0, -1, 0);
        send_frame(1, 0, -1, 0);
        idle(3);
        chk("t5_window_count", 72'(cap_cnt), 72'd48);
        chk("t5_done_count", 72'(done_cnt), 72'd2);
        check_table(5);

        // Random pixel frames with stalls, checked by the model every cycle.
        send_frame(2, 1, -1, 0);
        send_frame(2, 0, -1, 0);
        idle(2);

        // T6: reset after accepting (3,4), then a fresh frame.
        send_frame(0, 0, 3, 4);
        @(negedge clk);
        rst = 1'b1; valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_valid_after_rst", {71'b0, valid_o}, 72'd0);
        chk("t6_done_after_rst", {71'b0, done_o}, 72'd0);
        clear_cap();
        send_frame(0, 0, -1, 0);
        idle(3);
        chk("t6_window_count", 72'(cap_cnt), 72'd24);
        compare_ref("t6_window_vs_t2");

        mon_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
